psum_accum_unit: RTL

//  Parametrised successor to the core's PSUM path. Accepts COL-wide partial-sum vectors from the corelet
//  and either accumulates them into an internal PSUM buffer (WS mode) or stores them directly (OS mode).
//  A read-modify-write pipeline with forwarding sustains one vector per cycle to any address sequence.
//  A drain sequencer streams results out with optional ReLU over a valid/ready handshake.

---
 rtl/psum_pkg.sv | 33 +++
 rtl/psum_buf_sram.sv | 28 ++
 rtl/psum_accum_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared types and arithmetic for the PSUM accumulation unit.
package psum_pkg;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SAT_W = 32;

  // Signed add of two sign-extended lanes, clamped to the range of a bw-bit lane (bw < SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int                      bw);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi  = ((SAT_W+1)'(1) << (bw - 1)) - (SAT_W+1)'(1);
    lo  = -hi - (SAT_W+1)'(1);
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return SAT_W'(sum);
  endfunction

endpackage

// File: rtl/psum_buf_sram.sv
// 1R1W synchronous-read vector array; read-during-write to the same address returns old data.
module psum_buf_sram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; contents are zeroed explicitly through the CLEAR sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/psum_accum_unit.sv
// PSUM buffer with accumulate/overwrite RMW pipeline, clear sequencer and ReLU drain over valid/ready.
module psum_accum_unit
  import psum_pkg::*;
#(
  parameter  int COL     = 8,
  parameter  int PSUM_BW = 16,
  parameter  int DEPTH   = 2048,
  localparam int AW      = $clog2(DEPTH),
  localparam int VW      = PSUM_BW * COL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [VW-1:0] in_data,
  input  logic          clear_start,
  input  logic          drain_start,
  input  logic [AW-1:0] drain_base,
  input  logic [AW:0]   drain_len,
  input  logic          relu_en,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_data,
  output logic          out_last
);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] drain_addr_q;
  logic [AW:0]   remain_q;
  logic          relu_q;

  logic          s2_valid_q, s2_mode_q, s2_fwd_q;
  logic [AW-1:0] s2_addr_q;
  logic [VW-1:0] s2_data_q, s2_fwd_data_q, s2_old, s2_result;

  logic          rd_inflight_q, rd_last_q;
  logic [VW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [1:0]    fifo_cnt_q;
  logic [VW-1:0] fifo_wdata;

  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [VW-1:0] mem_wdata, mem_rdata;

  logic in_fire, drain_go, drain_rd, out_fire, fifo_push;

  assign in_ready  = (state_q == IDLE) && !clear_start && !drain_start && !reset;
  assign in_fire   = in_valid && in_ready;
  assign drain_go  = (state_q == IDLE) && !clear_start && drain_start && (drain_len != '0);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_data_q[fifo_rd_ptr_q] : '0;
  assign out_last  = out_valid && fifo_last_q[fifo_rd_ptr_q];
  assign busy      = (state_q != IDLE) || s2_valid_q;
  assign fifo_push = rd_inflight_q;

  // Credit check counts the slot freed by a same-cycle pop so a 2-entry FIFO streams at full rate.
  assign drain_rd = (state_q == DRAIN) && (remain_q != '0) &&
                    (({1'b0, fifo_cnt_q} + {2'b0, rd_inflight_q}) < (3'd2 + {2'b0, out_fire}));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_start)   state_d = CLEAR;
        else if (drain_go) state_d = DRAIN;
      end
      CLEAR: if (clr_cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      DRAIN: if (out_fire && out_last)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The S2 writeback of the forwarded result is the value S1 would have read had the array been write-first.
  always_comb begin
    s2_old    = s2_fwd_q ? s2_fwd_data_q : mem_rdata;
    s2_result = s2_data_q;
    if (s2_mode_q == MODE_WS) begin
      for (int i = 0; i < COL; i++) begin
        s2_result[i*PSUM_BW +: PSUM_BW] =
          PSUM_BW'(sat_add(SAT_W'($signed(s2_old[i*PSUM_BW +: PSUM_BW])),
                           SAT_W'($signed(s2_data_q[i*PSUM_BW +: PSUM_BW])), PSUM_BW));
      end
    end
  end

  always_comb begin
    fifo_wdata = mem_rdata;
    for (int i = 0; i < COL; i++) begin
      if (relu_q && mem_rdata[i*PSUM_BW + PSUM_BW - 1]) begin
        fifo_wdata[i*PSUM_BW +: PSUM_BW] = '0;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s2_addr_q;
    mem_wdata = s2_result;
    if (s2_valid_q) begin
      mem_we = 1'b1;
    end else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
  end

  assign mem_re    = in_fire || drain_rd;
  assign mem_raddr = drain_rd ? drain_addr_q : in_addr;

  psum_buf_sram #(
    .DEPTH (DEPTH),
    .WIDTH (VW),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      drain_addr_q  <= '0;
      remain_q      <= '0;
      relu_q        <= 1'b0;
      s2_valid_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
      s2_valid_q    <= in_fire;
      rd_inflight_q <= drain_rd;
      rd_last_q     <= drain_rd && (remain_q == (AW+1)'(1));
      if (drain_go) begin
        drain_addr_q <= drain_base;
        remain_q     <= drain_len;
        relu_q       <= relu_en;
      end else if (drain_rd) begin
        drain_addr_q <= (drain_addr_q == AW'(DEPTH - 1)) ? '0 : drain_addr_q + 1'b1;
        remain_q     <= remain_q - 1'b1;
      end
      if (fifo_push) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      if (out_fire)  fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, out_fire};
    end
  end

  // Datapath registers are qualified by the reset-cleared valids above.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s2_addr_q     <= in_addr;
      s2_data_q     <= in_data;
      s2_mode_q     <= mode;
      s2_fwd_q      <= s2_valid_q && (s2_addr_q == in_addr);
      s2_fwd_data_q <= s2_result;
    end
    if (fifo_push) begin
      fifo_data_q[fifo_wr_ptr_q] <= fifo_wdata;
      fifo_last_q[fifo_wr_ptr_q] <= rd_last_q;
    end
  end

endmodule
